nv_nvdla_mcif_write_eg_gen: RTL and testbench

Parametrised AXI write-response egress for MCIF. Each accepted B-channel response is routed to its client's context queue (CQ), which is popped. A registered per-client write-complete pulse is issued, and the burst length is returned to ingress so its outstanding-request counter can be decremented. Compared with the fixed five-client version, this block adds:
- B-channel backpressure when the matching CQ entry is absent;
- checking for out-of-range IDs;
- error-response logging with a sticky status and a saturating count.

---
 rtl/nv_nvdla_mcif_eg_pkg.sv | 44 ++++
 rtl/nv_nvdla_mcif_eg_errlog.sv | 47 ++++
 rtl/nv_nvdla_mcif_write_eg_gen.sv | 114 +++++++++++
 tb/tb_nv_nvdla_mcif_write_eg_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_mcif_eg_pkg.sv
// Shared definitions for the MCIF write egress: AXI response codes,
// CQ payload layout and a helper that slices one client's CQ head.
package nv_nvdla_mcif_eg_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_e;

  localparam int REQ_ACK_BIT = 0;
  localparam int LEN_LSB     = 1;

  // Widest CQ head vector any instance may present (8 clients, len up to 8 bits).
  localparam int MAX_CLIENTS = 8;
  localparam int MAX_SLICE_W = 9;
  localparam int MAX_PD_W    = MAX_CLIENTS * MAX_SLICE_W;

  function automatic logic [MAX_SLICE_W-1:0] cq_slice(input logic [MAX_PD_W-1:0] pd,
                                                      input int slice_w,
                                                      input int idx);
    logic [MAX_PD_W-1:0]    sh;
    logic [MAX_SLICE_W-1:0] mask;
    sh   = pd >> (idx * slice_w);
    mask = (MAX_SLICE_W'(1) << slice_w) - MAX_SLICE_W'(1);
    return sh[MAX_SLICE_W-1:0] & mask;
  endfunction

  function automatic logic [MAX_SLICE_W-1:0] cq_len(input logic [MAX_PD_W-1:0] pd,
                                                    input int slice_w,
                                                    input int idx);
    return cq_slice(pd, slice_w, idx) >> LEN_LSB;
  endfunction

  function automatic logic cq_ack(input logic [MAX_PD_W-1:0] pd,
                                  input int slice_w,
                                  input int idx);
    logic [MAX_SLICE_W-1:0] s;
    s = cq_slice(pd, slice_w, idx);
    return s[REQ_ACK_BIT];
  endfunction

endpackage

// File: rtl/nv_nvdla_mcif_eg_errlog.sv
// Error log: sticky first-error capture plus a saturating error counter.
// A clear arriving together with an error is overridden by that error.
module nv_nvdla_mcif_eg_errlog
  import nv_nvdla_mcif_eg_pkg::*;
#(
  parameter int CID_W     = 3,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 err_evt,
  input  logic [CID_W-1:0]     cid,
  input  logic [1:0]           resp,
  input  logic                 err_clr,
  output logic                 err_vld,
  output logic [CID_W-1:0]     err_client,
  output logic [1:0]           err_resp,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_vld    <= 1'b0;
      err_client <= '0;
      err_resp   <= AXI_RESP_OKAY;
      err_cnt    <= '0;
    end else if (err_evt) begin
      if (err_clr || !err_vld) begin
        err_vld    <= 1'b1;
        err_client <= cid;
        err_resp   <= resp;
      end
      if (err_clr)
        err_cnt <= ERR_CNT_W'(1);
      else if (err_cnt != CNT_MAX)
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end else if (err_clr) begin
      err_vld    <= 1'b0;
      err_client <= '0;
      err_resp   <= AXI_RESP_OKAY;
      err_cnt    <= '0;
    end
  end

endmodule

// File: rtl/nv_nvdla_mcif_write_eg_gen.sv
// MCIF write-response egress: holds one B response, pops the owning client's
// CQ, pulses write-complete and returns the burst length to ingress.
module nv_nvdla_mcif_write_eg_gen
  import nv_nvdla_mcif_eg_pkg::*;
#(
  parameter int NUM_CLIENTS = 5,
  parameter int AXI_ID_W    = 8,
  parameter int CID_W       = 3,
  parameter int LEN_W       = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rstn,
  input  logic                             noc2mcif_axi_b_bvalid,
  output logic                             noc2mcif_axi_b_bready,
  input  logic [AXI_ID_W-1:0]              noc2mcif_axi_b_bid,
  input  logic [1:0]                       noc2mcif_axi_b_bresp,
  input  logic [NUM_CLIENTS-1:0]           cq_rd_pvld,
  output logic [NUM_CLIENTS-1:0]           cq_rd_prdy,
  input  logic [NUM_CLIENTS*(LEN_W+1)-1:0] cq_rd_pd,
  output logic [NUM_CLIENTS-1:0]           wr_rsp_complete,
  output logic                             eg2ig_axi_vld,
  output logic [LEN_W-1:0]                 eg2ig_axi_len,
  input  logic                             err_clr,
  output logic                             err_vld,
  output logic [CID_W-1:0]                 err_client,
  output logic [1:0]                       err_resp,
  output logic [ERR_CNT_W-1:0]             err_cnt,
  output logic                             bad_id
);

  localparam int              SLICE_W = LEN_W + 1;
  localparam logic [CID_W:0]  NUM_C   = (CID_W+1)'(NUM_CLIENTS);

  logic                 hold_vld;
  logic [CID_W-1:0]     hold_cid;
  logic [1:0]           hold_resp;
  logic                 hit;
  logic                 retire;
  logic                 pop;
  logic                 sel_pvld;
  logic                 sel_ack;
  logic [LEN_W-1:0]     sel_len;
  logic [MAX_PD_W-1:0]  pd_ext;
  logic                 unused_bid_hi;

  assign unused_bid_hi = ^noc2mcif_axi_b_bid;
  assign pd_ext        = MAX_PD_W'(cq_rd_pd);
  assign hit           = {1'b0, hold_cid} < NUM_C;

  // Mux the held client's CQ head; out-of-range IDs select nothing.
  always_comb begin
    sel_pvld = 1'b0;
    sel_ack  = 1'b0;
    sel_len  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (hold_cid == CID_W'(i)) begin
        sel_pvld = cq_rd_pvld[i];
        sel_ack  = cq_ack(pd_ext, SLICE_W, i);
        sel_len  = LEN_W'(cq_len(pd_ext, SLICE_W, i));
      end
    end
  end

  assign pop                   = hold_vld & hit & sel_pvld;
  assign retire                = hold_vld & (~hit | sel_pvld);
  assign noc2mcif_axi_b_bready = ~hold_vld | retire;
  assign eg2ig_axi_vld         = pop;
  assign eg2ig_axi_len         = pop ? sel_len : '0;

  always_comb begin
    cq_rd_prdy = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      cq_rd_prdy[i] = pop & (hold_cid == CID_W'(i));
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      hold_vld        <= 1'b0;
      hold_cid        <= '0;
      hold_resp       <= AXI_RESP_OKAY;
      wr_rsp_complete <= '0;
      bad_id          <= 1'b0;
    end else begin
      if (noc2mcif_axi_b_bready) begin
        hold_vld <= noc2mcif_axi_b_bvalid;
        if (noc2mcif_axi_b_bvalid) begin
          hold_cid  <= noc2mcif_axi_b_bid[CID_W-1:0];
          hold_resp <= noc2mcif_axi_b_bresp;
        end
      end
      wr_rsp_complete <= (pop & sel_ack) ? cq_rd_prdy : '0;
      if (hold_vld & ~hit)
        bad_id <= 1'b1;
    end
  end

  nv_nvdla_mcif_eg_errlog #(
    .CID_W     (CID_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_errlog (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .err_evt         (pop & hold_resp[1]),
    .cid             (hold_cid),
    .resp            (hold_resp),
    .err_clr         (err_clr),
    .err_vld         (err_vld),
    .err_client      (err_client),
    .err_resp        (err_resp),
    .err_cnt         (err_cnt)
  );

endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg_gen.sv
// Bench for the MCIF write egress: a pending-response queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_nv_nvdla_mcif_write_eg_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bvalid = 1'b0;
  logic [7:0]  bid = '0;
  logic [1:0]  bresp = '0;
  logic [4:0]  pvld = 5'b11111;
  logic [14:0] pd = {3'b111, 3'b100, 3'b101, 3'b111, 3'b011};
  logic        err_clr = 1'b0;

  logic        bready, bready_s;
  logic [4:0]  prdy, prdy_s, cmp, cmp_s;
  logic        egv, egv_s;
  logic [1:0]  egl, egl_s;
  logic        evld, evld_s;
  logic [2:0]  ecl, ecl_s;
  logic [1:0]  ersp, ersp_s;
  logic [15:0] ecnt;
  logic [1:0]  ecnt_s;
  logic        bad, bad_s;

  int total = 0;
  int bad_n = 0;

  always #5 clk = ~clk;

  nv_nvdla_mcif_write_eg_gen dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .noc2mcif_axi_b_bvalid(bvalid), .noc2mcif_axi_b_bready(bready),
    .noc2mcif_axi_b_bid(bid), .noc2mcif_axi_b_bresp(bresp),
    .cq_rd_pvld(pvld), .cq_rd_prdy(prdy), .cq_rd_pd(pd),
    .wr_rsp_complete(cmp), .eg2ig_axi_vld(egv), .eg2ig_axi_len(egl),
    .err_clr(err_clr), .err_vld(evld), .err_client(ecl), .err_resp(ersp),
    .err_cnt(ecnt), .bad_id(bad));

  nv_nvdla_mcif_write_eg_gen #(.ERR_CNT_W(2)) dut_s (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .noc2mcif_axi_b_bvalid(bvalid), .noc2mcif_axi_b_bready(bready_s),
    .noc2mcif_axi_b_bid(bid), .noc2mcif_axi_b_bresp(bresp),
    .cq_rd_pvld(pvld), .cq_rd_prdy(prdy_s), .cq_rd_pd(pd),
    .wr_rsp_complete(cmp_s), .eg2ig_axi_vld(egv_s), .eg2ig_axi_len(egl_s),
    .err_clr(err_clr), .err_vld(evld_s), .err_client(ecl_s), .err_resp(ersp_s),
    .err_cnt(ecnt_s), .bad_id(bad_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: responses waiting for their CQ, plus the observable log state.
  typedef struct { int cid; logic [1:0] resp; } rsp_t;
  rsp_t pend[$];
  logic [4:0] m_cmp = '0;
  logic       m_bad = 1'b0;
  logic       m_evld = 1'b0;
  int         m_ecl = 0;
  logic [1:0] m_ersp = '0;
  int         m_cnt = 0;
  int         s_cnt = 0;

  always @(negedge clk) begin
    logic       e_bready, e_vld, retire, pop, is_err;
    logic [4:0] e_prdy, nxt_cmp;
    logic [1:0] e_len;
    int         c;
    if (!rstn) begin
      pend.delete();
      m_cmp = '0; m_bad = 0; m_evld = 0; m_ecl = 0; m_ersp = 0; m_cnt = 0; s_cnt = 0;
    end
    e_bready = 1; e_prdy = '0; e_vld = 0; e_len = '0; retire = 0; pop = 0; c = 0;
    if (pend.size() != 0) begin
      c = pend[0].cid;
      if (c >= 5) retire = 1;
      else if (pvld[c]) begin
        retire = 1; pop = 1; e_prdy[c] = 1'b1; e_vld = 1; e_len = pd[c*3+1 +: 2];
      end
      e_bready = retire;
    end
    chk("bready", 32'(bready), 32'(e_bready));
    chk("cq_rd_prdy", 32'(prdy), 32'(e_prdy));
    chk("eg2ig_vld", 32'(egv), 32'(e_vld));
    chk("eg2ig_len", 32'(egl), 32'(e_len));
    chk("complete", 32'(cmp), 32'(m_cmp));
    chk("bad_id", 32'(bad), 32'(m_bad));
    chk("err_vld", 32'(evld), 32'(m_evld));
    chk("err_client", 32'(ecl), 32'(m_ecl));
    chk("err_resp", 32'(ersp), 32'(m_ersp));
    chk("err_cnt", 32'(ecnt), 32'(m_cnt));
    chk("err_cnt_small", 32'(ecnt_s), 32'(s_cnt));
    chk("bready_small", 32'(bready_s), 32'(e_bready));
    if (rstn) begin
      nxt_cmp = '0;
      is_err = pop && pend[0].resp[1];
      if (pop && pd[c*3]) nxt_cmp[c] = 1'b1;
      if (retire && !pop) m_bad = 1;
      if (is_err) begin
        if (err_clr || !m_evld) begin
          m_evld = 1; m_ecl = c; m_ersp = pend[0].resp;
        end
        m_cnt = err_clr ? 1 : (m_cnt == 65535 ? 65535 : m_cnt + 1);
        s_cnt = err_clr ? 1 : (s_cnt == 3 ? 3 : s_cnt + 1);
      end else if (err_clr) begin
        m_evld = 0; m_ecl = 0; m_ersp = 0; m_cnt = 0; s_cnt = 0;
      end
      if (retire) void'(pend.pop_front());
      if (e_bready && bvalid) pend.push_back('{cid: int'(bid[2:0]), resp: bresp});
      m_cmp = nxt_cmp;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a response and hold it until the handshake completes.
  task automatic send(input logic [7:0] id, input logic [1:0] rsp);
    logic acc;
    int   n;
    acc = 0; n = 0;
    bvalid = 1; bid = id; bresp = rsp;
    do begin
      @(negedge clk); acc = bready;
      step(); n++;
    end while (!acc && n < 50);
    chk("send_handshake", 32'(acc), 32'd1);
    bvalid = 0;
  endtask

  initial begin
    int st;
    repeat (3) @(negedge clk);
    chk("reset_bready", 32'(bready), 32'd1);
    chk("reset_prdy", 32'(prdy), 32'd0);
    step(); rstn = 1; step();

    // single response, client 2 slice 3'b101
    send(8'h02, 2'd0);
    @(negedge clk);
    chk("t1_prdy", 32'(prdy), 32'b00100);
    chk("t1_len", 32'(egl), 32'd2);
    @(negedge clk);
    chk("t1_complete", 32'(cmp), 32'b00100);
    step();

    // back-to-back 0,1,4
    send(8'h00, 2'd0); send(8'h01, 2'd0); send(8'h04, 2'd0);
    @(negedge clk);
    chk("b2b_prdy", 32'(prdy), 32'b10000);
    chk("b2b_cmp_prev", 32'(cmp), 32'b00010);
    @(negedge clk);
    chk("b2b_cmp_last", 32'(cmp), 32'b10000);
    step();

    // stall on empty CQ 3
    pvld[3] = 0;
    send(8'h03, 2'd0);
    st = 0;
    repeat (4) begin
      @(negedge clk); if (!bready && prdy == 0) st++;
      step();
    end
    chk("stall_cycles", 32'(st), 32'd4);
    pvld[3] = 1;
    @(negedge clk);
    chk("stall_release_prdy", 32'(prdy), 32'b01000);
    chk("stall_release_len", 32'(egl), 32'd2);
    step();
    @(negedge clk);
    chk("stall_no_dup", 32'(prdy), 32'd0);
    chk("stall_no_cmp", 32'(cmp), 32'd0);
    step();

    // out-of-range ID, then upper-bit-aliased client 1
    send(8'h06, 2'd0);
    @(negedge clk);
    chk("oor_prdy", 32'(prdy), 32'd0);
    chk("oor_vld", 32'(egv), 32'd0);
    step();
    @(negedge clk);
    chk("oor_bad_id", 32'(bad), 32'd1);
    chk("oor_cmp", 32'(cmp), 32'd0);
    step();
    send(8'h21, 2'd0);
    @(negedge clk);
    chk("after_oor_prdy", 32'(prdy), 32'b00010);
    step(); step();

    // error logging
    send(8'h01, 2'd2); send(8'h04, 2'd3);
    step(); step();
    @(negedge clk);
    chk("err_vld_lit", 32'(evld), 32'd1);
    chk("err_client_lit", 32'(ecl), 32'd1);
    chk("err_resp_lit", 32'(ersp), 32'd2);
    chk("err_cnt_lit", 32'(ecnt), 32'd2);
    step();
    send(8'h00, 2'd2);
    err_clr = 1; step(); err_clr = 0;
    @(negedge clk);
    chk("clr_err_cnt", 32'(ecnt), 32'd1);
    chk("clr_err_client", 32'(ecl), 32'd0);
    chk("clr_err_vld", 32'(evld), 32'd1);
    step();

    // saturation of the narrow counter
    err_clr = 1; step(); err_clr = 0;
    repeat (5) send(8'h01, 2'd3);
    step(); step();
    @(negedge clk);
    chk("sat_small", 32'(ecnt_s), 32'd3);
    chk("sat_wide", 32'(ecnt), 32'd5);
    step();

    // reset while a response is stalled
    pvld[2] = 0;
    send(8'h02, 2'd3);
    rstn = 0; step(); step();
    pvld[2] = 1; rstn = 1;
    @(negedge clk);
    chk("rst_drop_prdy", 32'(prdy), 32'd0);
    chk("rst_bready", 32'(bready), 32'd1);
    chk("rst_err_cnt", 32'(ecnt), 32'd0);
    chk("rst_bad_id", 32'(bad), 32'd0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule
